// File: rtl/cw_merge_pkg.sv
// rtl/cw_merge_pkg.sv - shared types and default sizes for the CW stream merge
package cw_merge_pkg;

  localparam int DEF_DATA_WIDTH      = 16;
  localparam int DEF_FIFO_ADDR_WIDTH = 6;
  localparam int DEF_COUNT_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEND_LOCAL,
    SEND_FWD
  } arb_state_t;

  typedef enum logic {
    LOCAL,
    FWD
  } src_t;

  typedef enum logic [1:0] {
    MODE_SYNC,
    MODE_NORMAL,
    MODE_DROP
  } in_mode_t;

endpackage

// File: rtl/cw_packet_fifo.sv
// rtl/cw_packet_fifo.sv - packet FIFO with whole-packet commit/drop and FWFT read port
// Drop counter present only when CW_MERGE_DROP_COUNT_EN is defined.
module cw_packet_fifo
  import cw_merge_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int FIFO_ADDR_WIDTH = DEF_FIFO_ADDR_WIDTH,
  parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  i_tdata,
  input  logic                   i_tvalid,
  input  logic                   i_tlast,
  input  logic                   i_pop,
  output logic [DATA_WIDTH-1:0]  o_tdata,
  output logic                   o_tlast,
  output logic                   o_pkt_avail,
  output logic [COUNT_WIDTH-1:0] o_drop_count
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int PW    = FIFO_ADDR_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH:0] r_mem [DEPTH];
  logic [PW-1:0]       r_wr;
  logic [PW-1:0]       r_commit;
  logic [PW-1:0]       r_rd;
  logic [PW-1:0]       r_pkt_count;
  logic [DATA_WIDTH:0] r_rd_q;
  in_mode_t            r_mode;

  logic [PW-1:0] w_used;
  logic          w_full;
  logic          w_accept;
  logic          w_overflow;
  logic          w_commit;
  logic          w_pkt_done;
  logic [PW-1:0] w_rd_next;

  assign w_used     = r_wr - r_rd;
  assign w_full     = (w_used == PW'(DEPTH));
  assign w_accept   = i_tvalid && (r_mode == MODE_NORMAL) && !w_full;
  assign w_overflow = i_tvalid && (r_mode == MODE_NORMAL) && w_full;
  assign w_commit   = w_accept && i_tlast;
  assign w_pkt_done = i_pop && r_rd_q[DATA_WIDTH];
  assign w_rd_next  = i_pop ? (r_rd + PTR_ONE) : r_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr     <= '0;
      r_commit <= '0;
      r_mode   <= MODE_SYNC;
    end else begin
      case (r_mode)
        MODE_SYNC: begin
          if (i_tvalid && i_tlast) r_mode <= MODE_NORMAL;
        end
        MODE_NORMAL: begin
          if (w_overflow) begin
            // Rewind discards the partial packet; a tlast overflow finishes the drop at once.
            r_wr <= r_commit;
            if (!i_tlast) r_mode <= MODE_DROP;
          end else if (w_accept) begin
            r_wr <= r_wr + PTR_ONE;
            if (i_tlast) r_commit <= r_wr + PTR_ONE;
          end
        end
        MODE_DROP: begin
          if (i_tvalid && i_tlast) r_mode <= MODE_NORMAL;
        end
        default: r_mode <= MODE_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr[FIFO_ADDR_WIDTH-1:0]] <= {i_tlast, i_tdata};
  end

  // Prefetch reloads every cycle so a word committed while idle is valid by grant time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd   <= '0;
      r_rd_q <= '0;
    end else begin
      r_rd   <= w_rd_next;
      r_rd_q <= r_mem[w_rd_next[FIFO_ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_count <= '0;
    end else if (w_commit && !w_pkt_done) begin
      r_pkt_count <= r_pkt_count + PTR_ONE;
    end else if (!w_commit && w_pkt_done) begin
      r_pkt_count <= r_pkt_count - PTR_ONE;
    end
  end

  assign o_tdata     = r_rd_q[DATA_WIDTH-1:0];
  assign o_tlast     = r_rd_q[DATA_WIDTH];
  assign o_pkt_avail = (r_pkt_count != '0);

`ifdef CW_MERGE_DROP_COUNT_EN
  logic [COUNT_WIDTH-1:0] r_drop_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_count <= '0;
    end else if (w_overflow && (r_drop_count != '1)) begin
      r_drop_count <= r_drop_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign o_drop_count = r_drop_count;
`else
  assign o_drop_count = '0;
`endif

endmodule

// File: rtl/cw_stream_merge.sv
// rtl/cw_stream_merge.sv - merges CW local and forwarded streams into the Aurora A stream
// Drop counters are built only when CW_MERGE_DROP_COUNT_EN is defined.
module cw_stream_merge
  import cw_merge_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int FIFO_ADDR_WIDTH = DEF_FIFO_ADDR_WIDTH,
  parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  local_tdata,
  input  logic                   local_tvalid,
  input  logic                   local_tlast,
  input  logic [DATA_WIDTH-1:0]  fwd_tdata,
  input  logic                   fwd_tvalid,
  input  logic                   fwd_tlast,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [COUNT_WIDTH-1:0] local_drop_count,
  output logic [COUNT_WIDTH-1:0] fwd_drop_count
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  src_t       r_last_grant;
  src_t       w_last_grant_next;

  logic [DATA_WIDTH-1:0] w_local_data;
  logic                  w_local_last;
  logic                  w_local_avail;
  logic                  w_local_pop;
  logic [DATA_WIDTH-1:0] w_fwd_data;
  logic                  w_fwd_last;
  logic                  w_fwd_avail;
  logic                  w_fwd_pop;

  cw_packet_fifo #(
    .DATA_WIDTH     (DATA_WIDTH),
    .FIFO_ADDR_WIDTH(FIFO_ADDR_WIDTH),
    .COUNT_WIDTH    (COUNT_WIDTH)
  ) u_local_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_tdata     (local_tdata),
    .i_tvalid    (local_tvalid),
    .i_tlast     (local_tlast),
    .i_pop       (w_local_pop),
    .o_tdata     (w_local_data),
    .o_tlast     (w_local_last),
    .o_pkt_avail (w_local_avail),
    .o_drop_count(local_drop_count)
  );

  cw_packet_fifo #(
    .DATA_WIDTH     (DATA_WIDTH),
    .FIFO_ADDR_WIDTH(FIFO_ADDR_WIDTH),
    .COUNT_WIDTH    (COUNT_WIDTH)
  ) u_fwd_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_tdata     (fwd_tdata),
    .i_tvalid    (fwd_tvalid),
    .i_tlast     (fwd_tlast),
    .i_pop       (w_fwd_pop),
    .o_tdata     (w_fwd_data),
    .o_tlast     (w_fwd_last),
    .o_pkt_avail (w_fwd_avail),
    .o_drop_count(fwd_drop_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= FWD;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    m_tvalid          = 1'b0;
    m_tlast           = 1'b0;
    m_tdata           = '0;
    w_local_pop       = 1'b0;
    w_fwd_pop         = 1'b0;
    case (r_state)
      IDLE: begin
        // On a tie the source that did not win last time goes first.
        if (w_local_avail && (!w_fwd_avail || (r_last_grant == FWD))) begin
          w_state_next      = SEND_LOCAL;
          w_last_grant_next = LOCAL;
        end else if (w_fwd_avail) begin
          w_state_next      = SEND_FWD;
          w_last_grant_next = FWD;
        end
      end
      SEND_LOCAL: begin
        m_tvalid = 1'b1;
        m_tdata  = w_local_data;
        m_tlast  = w_local_last;
        if (m_tready) begin
          w_local_pop = 1'b1;
          if (w_local_last) w_state_next = IDLE;
        end
      end
      SEND_FWD: begin
        m_tvalid = 1'b1;
        m_tdata  = w_fwd_data;
        m_tlast  = w_fwd_last;
        if (m_tready) begin
          w_fwd_pop = 1'b1;
          if (w_fwd_last) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cw_stream_merge.sv
// tb/tb_cw_stream_merge.sv - randomized self-checking bench for cw_stream_merge
module tb_cw_stream_merge;

  localparam int DEPTH = 64;
`ifdef CW_MERGE_DROP_COUNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] local_tdata;
  logic        local_tvalid;
  logic        local_tlast;
  logic [15:0] fwd_tdata;
  logic        fwd_tvalid;
  logic        fwd_tlast;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic [15:0] local_drop_count;
  logic [15:0] fwd_drop_count;

  cw_stream_merge dut (
    .clk             (clk),
    .rst             (rst),
    .local_tdata     (local_tdata),
    .local_tvalid    (local_tvalid),
    .local_tlast     (local_tlast),
    .fwd_tdata       (fwd_tdata),
    .fwd_tvalid      (fwd_tvalid),
    .fwd_tlast       (fwd_tlast),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tlast         (m_tlast),
    .m_tready        (m_tready),
    .local_drop_count(local_drop_count),
    .fwd_drop_count  (fwd_drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_fail;
  int cyc;
  int sync_st [2];
  int dropping [2];
  int drops [2];
  int recv [2];
  int tlast_cyc [2];
  int rise_cyc;
  int tready_mode;
  logic tready_hold;
  int pkt_order [$];
  logic [16:0] exp_l [$];
  logic [16:0] exp_f [$];
  logic [16:0] cur_l [$];
  logic [16:0] cur_f [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic int qsize(input int s);
    return (s == 0) ? exp_l.size() : exp_f.size();
  endfunction

  function automatic int csize(input int s);
    return (s == 0) ? cur_l.size() : cur_f.size();
  endfunction

  function automatic int exp_drop(input int s);
    return DROP_EN ? drops[s] : 0;
  endfunction

  function automatic int order_at(input int i);
    return (i < pkt_order.size()) ? pkt_order[i] : -1;
  endfunction

  function automatic void model_reset();
    exp_l.delete();
    exp_f.delete();
    cur_l.delete();
    cur_f.delete();
    sync_st  = '{1, 1};
    dropping = '{0, 0};
    drops    = '{0, 0};
  endfunction

  // Reference rules: first packet after reset is discarded; a word arriving with
  // 64 words already buffered drops its whole packet.
  function automatic void model_word(input int s, input logic [15:0] d, input logic last);
    if (sync_st[s] != 0) begin
      if (last) sync_st[s] = 0;
      return;
    end
    if (dropping[s] == 0) begin
      if (qsize(s) + csize(s) == DEPTH) begin
        dropping[s] = 1;
        drops[s]++;
        if (s == 0) cur_l.delete(); else cur_f.delete();
      end else if (s == 0) begin
        cur_l.push_back({last, d});
      end else begin
        cur_f.push_back({last, d});
      end
    end
    if (last) begin
      if (dropping[s] == 0) begin
        if (s == 0) begin
          foreach (cur_l[i]) exp_l.push_back(cur_l[i]);
          cur_l.delete();
        end else begin
          foreach (cur_f[i]) exp_f.push_back(cur_f[i]);
          cur_f.delete();
        end
      end
      dropping[s] = 0;
    end
  endfunction

  task automatic drive(input int s, input logic v, input logic [15:0] d, input logic l);
    if (s == 0) begin
      local_tvalid = v; local_tdata = d; local_tlast = l;
    end else begin
      fwd_tvalid = v; fwd_tdata = d; fwd_tlast = l;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_pkt(input int s, input int len, input logic [15:0] base);
    logic [15:0] d;
    logic        l;
    for (int i = 0; i < len; i++) begin
      d     = base + 16'(i);
      d[15] = (s == 1);
      l     = (i == len - 1);
      model_word(s, d, l);
      if (l) tlast_cyc[s] = cyc;
      drive(s, 1'b1, d, l);
      @(posedge clk); #1;
    end
    drive(s, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((qsize(0) + qsize(1) + csize(0) + csize(1) != 0 || m_tvalid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("drain_in_time", 32'(n < budget), 32'd1);
    idle(2);
  endtask

  task automatic rand_src(input int s, input int npkt);
    int t;
    for (int k = 0; k < npkt; k++) begin
      t = 0;
      while (qsize(s) > 40 && t < 2000) begin
        idle(1);
        t++;
      end
      check_val("throttle_in_time", 32'(t < 2000), 32'd1);
      send_pkt(s, $urandom_range(1, 16), 16'($urandom_range(0, 32767)));
      idle($urandom_range(0, 3));
    end
  endtask

  task automatic monitor_loop();
    logic        in_pkt;
    logic        after_last;
    logic        stall_valid;
    logic        prev_valid;
    logic [16:0] stall_word;
    logic [16:0] w;
    int          s;
    int          cur_src;
    in_pkt = 0; after_last = 0; stall_valid = 0; prev_valid = 0;
    stall_word = '0; cur_src = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_pkt = 0; after_last = 0; stall_valid = 0; prev_valid = 0;
      end else begin
        if (m_tvalid && !prev_valid) rise_cyc = cyc;
        prev_valid = m_tvalid;
        if (after_last) check_val("gap_after_last", 32'(m_tvalid), 32'd0);
        if (in_pkt) check_val("valid_mid_pkt", 32'(m_tvalid), 32'd1);
        if (stall_valid) check_val("stall_stable", 32'({m_tlast, m_tdata}), 32'(stall_word));
        after_last  = 0;
        stall_valid = m_tvalid && !m_tready;
        stall_word  = {m_tlast, m_tdata};
        if (m_tvalid && m_tready) begin
          s = int'(m_tdata[15]);
          if (in_pkt) check_val("atomic_src", s, cur_src);
          else begin
            pkt_order.push_back(s);
            cur_src = s;
          end
          check_val("word_expected", 32'(qsize(s) > 0), 32'd1);
          if (qsize(s) > 0) begin
            w = (s == 0) ? exp_l.pop_front() : exp_f.pop_front();
            check_val("word", 32'({m_tlast, m_tdata}), 32'(w));
          end
          recv[s]++;
          in_pkt     = !m_tlast;
          after_last = m_tlast;
        end
      end
    end
  endtask

  task automatic tready_loop();
    forever begin
      @(posedge clk); #2;
      case (tready_mode)
        1:       m_tready = !m_tready;
        2:       m_tready = ($urandom_range(0, 9) < 8);
        default: m_tready = tready_hold;
      endcase
    end
  endtask

  task automatic cycle_loop();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  initial begin
    int r0;
    int r1;
    logic [15:0] d;
    n_checks = 0; n_fail = 0; cyc = 0; rise_cyc = 0;
    recv = '{0, 0}; tlast_cyc = '{0, 0};
    rst = 1'b1; m_tready = 1'b1; tready_hold = 1'b1; tready_mode = 0;
    drive(0, 1'b0, 16'h0000, 1'b0);
    drive(1, 1'b0, 16'h0000, 1'b0);
    model_reset();
    fork
      monitor_loop();
      tready_loop();
      cycle_loop();
    join_none

    idle(3);
    check_val("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check_val("rst_m_tlast", 32'(m_tlast), 32'd0);
    check_val("rst_m_tdata", 32'(m_tdata), 32'd0);
    check_val("rst_local_drops", 32'(local_drop_count), 32'd0);
    check_val("rst_fwd_drops", 32'(fwd_drop_count), 32'd0);
    rst = 1'b0;

    // First packet on each input is discarded while syncing.
    fork
      send_pkt(0, 3, 16'h0100);
      send_pkt(1, 2, 16'h0200);
    join
    idle(6);
    check_val("sync_no_output", recv[0] + recv[1], 0);

    // First tie after reset: local first.
    pkt_order.delete();
    fork
      send_pkt(0, 5, 16'h0300);
      send_pkt(1, 5, 16'h0400);
    join
    wait_drain(200);
    check_val("tie1_first", order_at(0), 0);
    check_val("tie1_second", order_at(1), 1);

    // Single 10-word local packet and its latency.
    r0 = recv[0];
    send_pkt(0, 10, 16'h0001);
    wait_drain(200);
    check_val("latency", rise_cyc - tlast_cyc[0], 2);
    check_val("pkt10_words", recv[0] - r0, 10);
    check_val("pkt10_fwd_drops", 32'(fwd_drop_count), exp_drop(1));

    // Tie after a local grant: fwd first.
    pkt_order.delete();
    fork
      send_pkt(0, 4, 16'h0500);
      send_pkt(1, 4, 16'h0600);
    join
    wait_drain(200);
    check_val("tie2_first", order_at(0), 1);
    check_val("tie2_second", order_at(1), 0);

    // Overflow with output stalled: 7 x 10 fwd words.
    tready_hold = 1'b0;
    idle(2);
    r1 = recv[1];
    for (int p = 0; p < 7; p++) send_pkt(1, 10, 16'h0700 + 16'(p * 16));
    idle(2);
    check_val("ovf_fwd_drops", 32'(fwd_drop_count), exp_drop(1));
    check_val("ovf_stalled_out", recv[1] - r1, 0);
    tready_hold = 1'b1;
    wait_drain(400);
    check_val("ovf_words_out", recv[1] - r1, 60);

    // Over-long local packet, then a short one.
    r0 = recv[0];
    send_pkt(0, 65, 16'h1000);
    send_pkt(0, 4, 16'h2000);
    wait_drain(300);
    check_val("long_local_drops", 32'(local_drop_count), exp_drop(0));
    check_val("long_after_words", recv[0] - r0, 4);

    // Ready toggling every cycle.
    r0 = recv[0];
    tready_mode = 1;
    send_pkt(0, 20, 16'h3000);
    wait_drain(400);
    tready_mode = 0;
    check_val("toggle_words", recv[0] - r0, 20);

    // Random traffic on both inputs with random ready.
    tready_mode = 2;
    fork
      rand_src(0, 40);
      rand_src(1, 40);
    join
    wait_drain(3000);
    tready_mode = 0;
    check_val("rand_local_drops", 32'(local_drop_count), exp_drop(0));
    check_val("rand_fwd_drops", 32'(fwd_drop_count), exp_drop(1));

    // Reset during an output packet and a partial fwd input packet.
    tready_hold = 1'b1;
    send_pkt(0, 20, 16'h4000);
    for (int i = 0; i < 5; i++) begin
      d = 16'h8000 | (16'h5000 + 16'(i));
      model_word(1, d, 1'b0);
      drive(1, 1'b1, d, 1'b0);
      idle(1);
    end
    check_val("pre_reset_valid", 32'(m_tvalid), 32'd1);
    rst = 1'b1;
    #1;
    check_val("reset_m_tvalid", 32'(m_tvalid), 32'd0);
    check_val("reset_m_tlast", 32'(m_tlast), 32'd0);
    drive(1, 1'b0, 16'h0000, 1'b0);
    model_reset();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("post_rst_local_drops", 32'(local_drop_count), 32'd0);
    check_val("post_rst_fwd_drops", 32'(fwd_drop_count), 32'd0);
    r0 = recv[0];
    r1 = recv[1];
    fork
      begin
        send_pkt(1, 5, 16'h5005);
        send_pkt(1, 6, 16'h6000);
      end
      begin
        send_pkt(0, 3, 16'h7000);
        send_pkt(0, 4, 16'h7100);
      end
    join
    wait_drain(300);
    check_val("post_rst_local_words", recv[0] - r0, 4);
    check_val("post_rst_fwd_words", recv[1] - r1, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
